// File: rtl/aging_table_arbiter.sv
// Arbitrates aging-table RAM access between the packet path and the timeout inspector, dropping stale inspector write-backs.
// Grants are combinational; the RAM command is registered one cycle later and read data returns 3 cycles after the grant.
module aging_table_arbiter #(
    parameter int w_agingTb = 17,
    parameter int d_agingTb = 3,
    parameter int MAX_WAIT  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pkt_req,
    input  logic                 pkt_wr,
    input  logic [d_agingTb-1:0] pkt_idx,
    input  logic [w_agingTb-1:0] pkt_data,
    output logic                 pkt_gnt,
    output logic                 pkt_rdValid,
    output logic [w_agingTb-1:0] pkt_ctx,
    input  logic                 agi_req,
    input  logic                 agi_wr,
    input  logic [d_agingTb-1:0] agi_idx,
    input  logic [w_agingTb-1:0] agi_data,
    output logic                 agi_gnt,
    output logic                 agi_rdValid,
    output logic [w_agingTb-1:0] agi_ctx,
    output logic                 agi_wrDrop,
    output logic [d_agingTb-1:0] ram_idx,
    output logic [w_agingTb-1:0] ram_data,
    output logic                 ram_rden,
    output logic                 ram_wren,
    input  logic [w_agingTb-1:0] ram_ctx
);
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {L_IDLE, L_HELD, L_DIRTY} lock_state_t;

    typedef struct packed {
        logic                 rden;
        logic                 wren;
        logic                 agi;
        logic [d_agingTb-1:0] idx;
        logic [w_agingTb-1:0] data;
    } ram_cmd_t;

    typedef struct packed {
        logic vld;
        logic agi;
    } tag_t;

    logic [CW-1:0]        starve_cnt;
    logic                 agi_starved;
    logic                 agi_win;
    lock_state_t          lock_state;
    lock_state_t          lock_next;
    logic [d_agingTb-1:0] lock_idx;
    logic                 wr_drop;
    ram_cmd_t             cmd_next;
    ram_cmd_t             cmd_q;
    logic                 drop_q;
    tag_t                 tag_s1;
    tag_t                 tag_s2;
    logic [w_agingTb-1:0] pkt_ctx_q;
    logic [w_agingTb-1:0] agi_ctx_q;

    // Packet path wins ties unless the inspector has waited MAX_WAIT cycles.
    always_comb begin
        agi_starved = (starve_cnt == CW'(MAX_WAIT));
        agi_win     = agi_req & (~pkt_req | agi_starved);
        pkt_gnt     = reset & pkt_req & ~agi_win;
        agi_gnt     = reset & agi_win;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!agi_req || agi_gnt) begin
            starve_cnt <= '0;
        end else if (!agi_starved) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    // Lock FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            lock_state <= L_IDLE;
            lock_idx   <= '0;
        end else begin
            lock_state <= lock_next;
            if (agi_gnt && !agi_wr) begin
                lock_idx <= agi_idx;
            end
        end
    end

    // Lock FSM: next state
    always_comb begin
        lock_next = lock_state;
        case (lock_state)
            L_HELD: begin
                if (pkt_gnt && pkt_wr && (pkt_idx == lock_idx)) begin
                    lock_next = L_DIRTY;
                end
            end
            L_IDLE, L_DIRTY: lock_next = lock_state;
            default: lock_next = L_IDLE;
        endcase
        if (agi_gnt) begin
            lock_next = agi_wr ? L_IDLE : L_HELD;
        end
    end

    // Lock FSM: outputs -- the inspector's write-back is stale once the packet path has rewritten the locked entry.
    always_comb begin
        wr_drop = agi_gnt & agi_wr & (lock_state == L_DIRTY) & (agi_idx == lock_idx);
    end

    always_comb begin
        cmd_next = '0;
        if (pkt_gnt) begin
            cmd_next.rden = ~pkt_wr;
            cmd_next.wren = pkt_wr;
            cmd_next.agi  = 1'b0;
            cmd_next.idx  = pkt_idx;
            cmd_next.data = pkt_wr ? pkt_data : '0;
        end else if (agi_gnt) begin
            cmd_next.rden = ~agi_wr;
            cmd_next.wren = agi_wr & ~wr_drop;
            cmd_next.agi  = 1'b1;
            cmd_next.idx  = agi_idx;
            cmd_next.data = agi_wr ? agi_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd_q  <= '0;
            drop_q <= 1'b0;
            tag_s1 <= '0;
            tag_s2 <= '0;
        end else begin
            cmd_q  <= cmd_next;
            drop_q <= wr_drop;
            tag_s1 <= '{vld: cmd_q.rden, agi: cmd_q.agi};
            tag_s2 <= tag_s1;
        end
    end

    assign ram_idx    = cmd_q.idx;
    assign ram_data   = cmd_q.data;
    assign ram_rden   = cmd_q.rden;
    assign ram_wren   = cmd_q.wren;
    assign agi_wrDrop = drop_q;

    // RAM data is only valid in the return cycle, so ctx passes it through then and holds it afterwards.
    always_comb begin
        pkt_rdValid = tag_s2.vld & ~tag_s2.agi;
        agi_rdValid = tag_s2.vld & tag_s2.agi;
        pkt_ctx     = pkt_rdValid ? ram_ctx : pkt_ctx_q;
        agi_ctx     = agi_rdValid ? ram_ctx : agi_ctx_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pkt_ctx_q <= '0;
            agi_ctx_q <= '0;
        end else begin
            if (pkt_rdValid) begin
                pkt_ctx_q <= ram_ctx;
            end
            if (agi_rdValid) begin
                agi_ctx_q <= ram_ctx;
            end
        end
    end

endmodule

// File: tb/tb_aging_table_arbiter.sv
// Scoreboard bench for aging_table_arbiter with a 2-cycle-latency RAM model.
module tb_aging_table_arbiter;
    logic        clk;
    logic        reset;
    logic        pkt_req, pkt_wr, agi_req, agi_wr;
    logic [2:0]  pkt_idx, agi_idx, ram_idx;
    logic [16:0] pkt_data, agi_data, ram_data, ram_ctx, pkt_ctx, agi_ctx;
    logic        pkt_gnt, pkt_rdValid, agi_gnt, agi_rdValid, agi_wrDrop, ram_rden, ram_wren;

    aging_table_arbiter #(.w_agingTb(17), .d_agingTb(3), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .pkt_req(pkt_req), .pkt_wr(pkt_wr), .pkt_idx(pkt_idx), .pkt_data(pkt_data),
        .pkt_gnt(pkt_gnt), .pkt_rdValid(pkt_rdValid), .pkt_ctx(pkt_ctx),
        .agi_req(agi_req), .agi_wr(agi_wr), .agi_idx(agi_idx), .agi_data(agi_data),
        .agi_gnt(agi_gnt), .agi_rdValid(agi_rdValid), .agi_ctx(agi_ctx), .agi_wrDrop(agi_wrDrop),
        .ram_idx(ram_idx), .ram_data(ram_data), .ram_rden(ram_rden), .ram_wren(ram_wren),
        .ram_ctx(ram_ctx)
    );

    typedef struct {
        logic [16:0] ctx;
        int          cyc;
    } rd_exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          mon_en = 0;
    logic [16:0] mem [8];
    logic [16:0] rd_s1, rd_s2;
    rd_exp_t     pkt_rd_q[$];
    rd_exp_t     agi_rd_q[$];
    rd_exp_t     e;
    logic [19:0] exp_wr_q[$];
    int          exp_drop_q[$];
    bit          exp_gnt_q[$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: read data appears 2 cycles after ram_rden.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_idx] <= ram_data;
        if (ram_rden) rd_s1 <= mem[ram_idx];
        rd_s2 <= rd_s1;
    end
    assign ram_ctx = rd_s2;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("gnt_onehot", 64'(pkt_gnt & agi_gnt), 0);
            check("rd_wr_excl", 64'(ram_rden & ram_wren), 0);
            if (pkt_gnt || agi_gnt) begin
                if (exp_gnt_q.size() == 0) flag("gnt_unexpected", "got a grant, required none");
                else check("gnt_src", 64'(agi_gnt), 64'(exp_gnt_q.pop_front()));
            end
            if (pkt_rdValid) begin
                if (pkt_rd_q.size() == 0) flag("pkt_rd_unexpected", "got pkt_rdValid, required none");
                else begin
                    e = pkt_rd_q.pop_front();
                    check("pkt_ctx", 64'(pkt_ctx), 64'(e.ctx));
                    check("pkt_rd_cyc", 64'(cyc), 64'(e.cyc));
                end
            end
            if (agi_rdValid) begin
                if (agi_rd_q.size() == 0) flag("agi_rd_unexpected", "got agi_rdValid, required none");
                else begin
                    e = agi_rd_q.pop_front();
                    check("agi_ctx", 64'(agi_ctx), 64'(e.ctx));
                    check("agi_rd_cyc", 64'(cyc), 64'(e.cyc));
                end
            end
            if (ram_wren) begin
                if (exp_wr_q.size() == 0) flag("ram_wr_unexpected", "got ram_wren, required none");
                else check("ram_wr", 64'({ram_idx, ram_data}), 64'(exp_wr_q.pop_front()));
            end
            if (agi_wrDrop) begin
                if (exp_drop_q.size() == 0) flag("drop_unexpected", "got agi_wrDrop, required none");
                else check("drop_cyc", 64'(cyc), 64'(exp_drop_q.pop_front()));
            end
        end
    end

    // Drives one request from posedge+1 until granted, then releases it at the next posedge+1.
    task automatic drive(input bit agi, input bit wr, input logic [2:0] idx, input logic [16:0] data,
                         input bit exp_rd, input logic [16:0] exp_ctx, input bit exp_drop, output int gcyc);
        bit      got;
        rd_exp_t r;
        got  = 0;
        gcyc = -1;
        if (agi) begin
            agi_req = 1; agi_wr = wr; agi_idx = idx; agi_data = data;
        end else begin
            pkt_req = 1; pkt_wr = wr; pkt_idx = idx; pkt_data = data;
        end
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = agi ? agi_gnt : pkt_gnt;
        end
        if (!got) begin
            flag("grant_timeout", "got no grant in 30 cycles, required a grant");
        end else begin
            gcyc = cyc;
            if (!wr) begin
                r.ctx = exp_ctx;
                r.cyc = cyc + 3;
                if (exp_rd) begin
                    if (agi) agi_rd_q.push_back(r);
                    else pkt_rd_q.push_back(r);
                end
            end else if (exp_drop) begin
                exp_drop_q.push_back(cyc + 1);
            end else begin
                exp_wr_q.push_back({idx, data});
            end
        end
        @(posedge clk);
        #1;
        if (agi) begin
            agi_req = 0; agi_wr = 0; agi_idx = 0; agi_data = 0;
        end else begin
            pkt_req = 0; pkt_wr = 0; pkt_idx = 0; pkt_data = 0;
        end
    endtask

    task automatic op(input bit agi, input bit wr, input logic [2:0] idx, input logic [16:0] data,
                      input logic [16:0] exp_ctx, input bit exp_drop);
        int g;
        exp_gnt_q.push_back(agi);
        drive(agi, wr, idx, data, 1'b1, exp_ctx, exp_drop, g);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        int g1, g2;
        reset = 0;
        pkt_req = 0; pkt_wr = 0; pkt_idx = 0; pkt_data = 0;
        agi_req = 0; agi_wr = 0; agi_idx = 0; agi_data = 0;
        for (int i = 0; i < 8; i++) mem[i] = 17'h10000 | 17'(i);
        mem[5] = 17'h10064;
        rd_s1 = 0;
        rd_s2 = 0;

        // Reset: requests present but nothing granted, all outputs quiet.
        pkt_req = 1; agi_req = 1;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            check("reset_gnt", 64'({pkt_gnt, agi_gnt}), 0);
            check("reset_outputs", 64'({pkt_rdValid, agi_rdValid, agi_wrDrop, ram_rden, ram_wren, ram_idx, ram_data}), 0);
            check("reset_ctx", 64'({pkt_ctx, agi_ctx}), 0);
        end
        @(posedge clk);
        #1;
        pkt_req = 0; agi_req = 0;
        reset = 1;
        mon_en = 1;
        @(posedge clk);
        #1;

        // Starvation: both requesting writes to idx 7 -> P P P P A P P P P A.
        for (int k = 0; k < 10; k++) begin
            exp_gnt_q.push_back(k % 5 == 4);
            exp_wr_q.push_back((k % 5 == 4) ? {3'd7, 17'h00222} : {3'd7, 17'h00111});
        end
        pkt_req = 1; pkt_wr = 1; pkt_idx = 7; pkt_data = 17'h00111;
        agi_req = 1; agi_wr = 1; agi_idx = 7; agi_data = 17'h00222;
        repeat (10) @(posedge clk);
        #1;
        pkt_req = 0; pkt_wr = 0; pkt_idx = 0; pkt_data = 0;
        agi_req = 0; agi_wr = 0; agi_idx = 0; agi_data = 0;

        // Packet read returns RAM data 3 cycles after grant.
        op(0, 0, 3'd5, 0, 17'h10064, 0);

        // Inspector write-back after a packet rewrite of the locked entry is dropped.
        op(1, 0, 3'd3, 0, 17'h10003, 0);
        op(0, 1, 3'd3, 17'h100C8, 0, 0);
        op(1, 1, 3'd3, 17'h00000, 0, 1);
        op(0, 0, 3'd3, 0, 17'h100C8, 0);

        // Packet rewrite of another entry leaves the write-back alone.
        op(1, 0, 3'd3, 0, 17'h100C8, 0);
        op(0, 1, 3'd4, 17'h00ABC, 0, 0);
        op(1, 1, 3'd3, 17'h00000, 0, 0);
        op(0, 0, 3'd3, 0, 17'h00000, 0);
        op(0, 0, 3'd4, 0, 17'h00ABC, 0);

        // Back-to-back inspector reads; the lock follows the later index.
        exp_gnt_q.push_back(1);
        drive(1, 0, 3'd2, 0, 1'b1, 17'h10002, 0, g1);
        exp_gnt_q.push_back(1);
        drive(1, 0, 3'd6, 0, 1'b1, 17'h10006, 0, g2);
        check("b2b_gnt_cyc", 64'(g2), 64'(g1 + 1));
        op(0, 1, 3'd6, 17'h00066, 0, 0);
        op(1, 1, 3'd6, 17'h11111, 0, 1);
        op(0, 0, 3'd6, 0, 17'h00066, 0);

        // Simultaneous writes to the locked entry: packet first, inspector dropped.
        op(1, 0, 3'd1, 0, 17'h10001, 0);
        exp_gnt_q.push_back(0);
        exp_gnt_q.push_back(1);
        fork
            drive(0, 1, 3'd1, 17'h00055, 1'b0, 0, 0, g1);
            drive(1, 1, 3'd1, 17'h00077, 1'b0, 0, 1, g2);
        join
        check("same_cyc_order", 64'(g2), 64'(g1 + 1));
        op(0, 0, 3'd1, 0, 17'h00055, 0);

        // Index 0 is passed through.
        op(0, 1, 3'd0, 17'h1ABCD, 0, 0);
        op(1, 0, 3'd0, 0, 17'h1ABCD, 0);
        op(0, 0, 3'd0, 0, 17'h1ABCD, 0);
        repeat (6) @(posedge clk);
        #1;

        // One-cycle reset right after a read grant: the read never returns.
        exp_gnt_q.push_back(0);
        drive(0, 0, 3'd5, 0, 1'b0, 0, 0, g1);
        reset = 0;
        @(posedge clk);
        #1;
        reset = 1;
        @(negedge clk);
        check("post_reset_outputs", 64'({pkt_gnt, agi_gnt, pkt_rdValid, agi_rdValid, agi_wrDrop, ram_rden, ram_wren, ram_idx, ram_data}), 0);
        check("post_reset_ctx", 64'({pkt_ctx, agi_ctx}), 0);
        repeat (8) @(posedge clk);
        #1;

        check("gnt_left", 64'(exp_gnt_q.size()), 0);
        check("pkt_rd_left", 64'(pkt_rd_q.size()), 0);
        check("agi_rd_left", 64'(agi_rd_q.size()), 0);
        check("wr_left", 64'(exp_wr_q.size()), 0);
        check("drop_left", 64'(exp_drop_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/aging_table_arbiter.md
AGING_TABLE_ARBITER -- requirements
Module: aging_table_arbiter

Parameters
REQ-001 The block SHALL take parameter w_agingTb, default 17, as the aging-table entry width (bit 16 = valid, bits 15:0 = timestamp).
REQ-002 The block SHALL take parameter d_agingTb, default 3, as the aging-table index width.
REQ-003 The block SHALL take parameter MAX_WAIT, default 4, as the inspector starvation limit in cycles.

Interface
REQ-004 clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 pkt_req / pkt_wr / pkt_idx / pkt_data  input  1/1/d_agingTb/w_agingTb  packet-path request: request, write (1) or read (0), entry index, write data.
REQ-007 pkt_gnt  output  1  packet-path grant.
REQ-008 pkt_rdValid / pkt_ctx  output  1/w_agingTb  packet-path read return (valid, data).
REQ-009 agi_req / agi_wr / agi_idx / agi_data  input  1/1/d_agingTb/w_agingTb  timeout-inspector request: request, write (1) or read (0), entry index, write data.
REQ-010 agi_gnt  output  1  inspector grant.
REQ-011 agi_rdValid / agi_ctx  output  1/w_agingTb  inspector read return (valid, data).
REQ-012 agi_wrDrop  output  1  pulse: the granted inspector write was suppressed.
REQ-013 ram_idx / ram_data / ram_rden / ram_wren  output  d_agingTb/w_agingTb/1/1  aging-table RAM command.
REQ-014 ram_ctx  input  w_agingTb  RAM read data, valid exactly 2 cycles after ram_rden.

Function
REQ-015 Requesters SHALL hold req, wr, idx and data stable until they see their grant.
REQ-016 Grants SHALL be combinational and one-hot; at most one grant per cycle.
REQ-017 Arbitration SHALL give pkt priority when both request, except that agi wins when its starvation counter equals MAX_WAIT.
REQ-018 The starvation counter SHALL increment each cycle agi_req=1 without agi_gnt, SHALL saturate at MAX_WAIT, and SHALL clear on agi_gnt or when agi_req=0.
REQ-019 The granted command SHALL appear on ram_* registered in the cycle after the grant; ram_rden and ram_wren SHALL be mutually exclusive single-cycle pulses; ram_* SHALL be 0 in idle cycles.
REQ-020 Read return: rdValid SHALL pulse for the originating requester exactly 3 cycles after its read grant, with ctx equal to ram_ctx in that cycle; a 2-stage tag pipeline SHALL carry the requester id; ctx SHALL hold its last value otherwise.
REQ-021 Back-to-back reads SHALL be supported every cycle, with in-order returns.
REQ-022 Lock FSM states: L_IDLE, L_HELD, L_DIRTY; register lock_idx.
REQ-023 An agi read grant SHALL load lock_idx=agi_idx and go to L_HELD from any state.
REQ-024 A pkt write grant with pkt_idx==lock_idx in L_HELD SHALL go to L_DIRTY; pkt reads and other indices SHALL not change state.
REQ-025 An agi write grant SHALL return the FSM to L_IDLE.
REQ-026 If an agi write is granted in L_DIRTY with agi_idx==lock_idx, the RAM write SHALL be suppressed (ram_wren=0), and agi_wrDrop SHALL pulse in the same registered cycle as the suppressed command; otherwise the write SHALL proceed.
REQ-027 A pkt write and an agi write to the same idx requested in the same cycle SHALL both be granted in priority order (pkt first) and SHALL both be subject to REQ-024 and REQ-026.
REQ-028 The block SHALL perform no index-range filtering; index 0 SHALL be passed through unchanged.

Reset
REQ-029 While reset=0 at a clock edge, all outputs SHALL be 0, the counter SHALL be 0, the lock FSM SHALL be L_IDLE with lock_idx=0, and the tag pipeline SHALL be cleared.
REQ-030 Reads granted before reset SHALL produce no rdValid after reset.
REQ-031 Grants SHALL be 0 while reset=0.

Verification
REQ-032 pkt read idx 5 granted at cycle T, RAM returns 17'h1_0064 -> pkt_rdValid=1 and pkt_ctx=17'h1_0064 at T+3; agi_rdValid stays 0.
REQ-033 pkt_req and agi_req held high continuously -> agi granted exactly once per 5 cycles (4 pkt grants then 1 agi grant).
REQ-034 agi read idx 3; pkt write idx 3 data 17'h1_00C8; agi write idx 3 data 0 -> ram_wren stays low for the agi write, agi_wrDrop pulses once, and the entry reads back 17'h1_00C8.
REQ-035 Same sequence as REQ-034 but the pkt write targets idx 4 -> the agi write to idx 3 reaches the RAM and agi_wrDrop stays 0.
REQ-036 agi reads idx 2 and idx 6 granted on consecutive cycles -> two agi_rdValid pulses on consecutive cycles, in order, with lock_idx=6.
REQ-037 reset asserted for one cycle, one cycle after a read grant -> no rdValid follows, and all outputs are 0 on the cycle after reset.
